mpadder_arbiter: RTL and testbench
==================================

// Module: mpadder_arbiter
// PURPOSE
//  Shares one multi-cycle mpadder instance (A+B -> C, start/done protocol) between two clients.
//  Clients are, e.g., the Montgomery core and the exponentiation controller.
//  Grants one request at a time, round-robin. Latches the winner's operands and pulses start.
//  Waits for done, then returns the registered sum with a per-client done pulse.
//  Guards against a hung adder with a timeout counter.
// PARAMETERS
//  WIDTH    128  operand width in bits; sum is WIDTH+1 bits
//  TIMEOUT  15   max cycles in WAIT before error; counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk       in   1        single clock, rising edge
//  resetn    in   1        reset, asynchronous assert, active-low
//  req0      in   1        client 0 request; held high with stable a0/b0 until done0
//  a0, b0    in   WIDTH    client 0 operands
//  req1      in   1        client 1 request; same rules as req0
//  a1, b1    in   WIDTH    client 1 operands
//  gnt0      out  1        high from the grant cycle until done0 inclusive
//  gnt1      out  1        as gnt0, for client 1
//  done0     out  1        one-cycle pulse: result valid for client 0
//  done1     out  1        one-cycle pulse: result valid for client 1
//  result    out  WIDTH+1  registered sum; holds its value until the next RESP
//  err       out  1        sticky; set on timeout, cleared only by reset
//  add_start out  1        to mpadder start
//  add_A     out  WIDTH    to mpadder A; driven from operand regs, stable ISSUE..RESP
//  add_B     out  WIDTH    to mpadder B; as add_A
//  add_C     in   WIDTH+1  from mpadder C
//  add_done  in   1        from mpadder done
// BEHAVIOUR
//  Reset (resetn=0, async): all outputs 0; state=IDLE, last=1 (client 0 favoured first); counter=0.
//    Reset mid-operation abandons the job; no done pulse is issued.
//    The adder is reset separately by the system.
//  FSM, 2-bit, states IDLE(0) ISSUE(1) WAIT(2) RESP(3):
//   IDLE:  if req0|req1, pick winner w; latch aw/bw into opA/opB; set gnt_w; go ISSUE.
//          Otherwise stay in IDLE.
//          Both requesting: w = ~last. Single requester always wins.
//   ISSUE: add_start=1 for exactly one cycle; counter cleared; go WAIT.
//   WAIT:  add_start=0; counter increments each cycle.
//          On add_done: result<=add_C; go RESP.
//          Else, if counter==TIMEOUT: result<=0; err<=1; go RESP.
//          add_done and timeout in the same cycle: add_done wins and err is not set.
//   RESP:  done_w=1 for one cycle; last<=w; go IDLE.
//          gnt_w drops at the exit from RESP, so gnt_w=0 on the first IDLE cycle.
//  Latency: req seen in IDLE at cycle t -> add_start at t+1 -> done_w at (cycle of add_done)+1.
//    With the 2-word mpadder, done_w comes 5 cycles after t.
//  A req still high on the IDLE cycle after done is a new request.
//    It is arbitrated again, and round-robin prevents starvation.
//  add_done outside WAIT is ignored. Operand changes after the grant are ignored (already latched).
//  Dropping req before done (client protocol violation): job still completes; done pulse still issued.
//  Arithmetic: no modification. result = add_C zero-extended, never truncated. Overflow lives in bit WIDTH.
// STRUCTURE
//  Shared package: state encodings (ST_IDLE..ST_RESP) and client index constants (CL0, CL1).
//  Natural sub-module: rr_arb2, a 2-way round-robin pick.
//    Inputs: req[1:0], last. Output: onehot gnt.
//    Combinational; the last-pointer register stays in the parent.
//  Everything else (FSM, operand regs, result reg, timeout counter) lives in one module.
// TESTING (bench instantiates a real mpadder, plus a stub adder for the timeout case)
//  Single add: req0, a0=2^127, b0=2^127 -> add_start 1 cycle later; done0 one pulse; result=2^128; gnt1=0.
//  Contention: req0 and req1 in the same cycle after reset -> client 0 first.
//    Client 1 next; done1 result = a1+b1 (a1=5, b1=7 -> 12).
//  Round-robin fairness: req0 and req1 held high for 6 jobs -> grants alternate 0,1,0,1,0,1;
//    never two consecutive grants to one client.
//  Timeout: stub never asserts add_done -> done_x after TIMEOUT+3 cycles; result=0; err=1 and stays 1.
//  Reset mid-job: resetn low during WAIT -> outputs 0 immediately (async).
//    No done pulse. A new req after release is served normally with client 0 favoured.
//  Operand stability: change a0 to 0 after gnt0 -> add_A unchanged; result reflects the latched operands.

Source files
------------

// File: rtl/mpadder_arbiter_pkg.sv
// Shared encodings for the two-client mpadder arbiter.
package mpadder_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic CL0 = 1'b0;
    localparam logic CL1 = 1'b1;

endpackage

// File: rtl/mpadder_arbiter_rr_arb2.sv
// Two-way round-robin pick: single requester wins, contention goes to the client not served last.
module mpadder_arbiter_rr_arb2
    import mpadder_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_req[CL0] && i_req[CL1]) begin
            if (i_last == CL1) begin
                o_gnt[CL0] = 1'b1;
            end else begin
                o_gnt[CL1] = 1'b1;
            end
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/mpadder_arbiter.sv
// Shares one start/done mpadder between two clients with round-robin grant and a hang timeout.
module mpadder_arbiter
    import mpadder_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH:0]   result,
    output logic             err,
    output logic             add_start,
    output logic [WIDTH-1:0] add_A,
    output logic [WIDTH-1:0] add_B,
    input  logic [WIDTH:0]   add_C,
    input  logic             add_done
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last;
    logic             r_win;
    logic [1:0]       r_gnt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH:0]   r_result;
    logic             r_err;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       w_pick;
    logic             w_timeout;

    mpadder_arbiter_rr_arb2 u_arb (
        .i_req  ({req1, req0}),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    assign w_timeout = (r_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (|w_pick) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  if (add_done || w_timeout) w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last   <= CL1;
            r_win    <= CL0;
            r_gnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (|w_pick) begin
                        r_win  <= w_pick[CL1];
                        r_gnt  <= w_pick;
                        r_op_a <= w_pick[CL1] ? a1 : a0;
                        r_op_b <= w_pick[CL1] ? b1 : b0;
                    end
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // A done arriving on the timeout cycle still counts as success.
                    if (add_done) begin
                        r_result <= add_C;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_last <= r_win;
                    r_gnt  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        add_start = (r_state == ST_ISSUE);
        done0     = (r_state == ST_RESP) && (r_win == CL0);
        done1     = (r_state == ST_RESP) && (r_win == CL1);
        gnt0      = r_gnt[CL0];
        gnt1      = r_gnt[CL1];
        add_A     = r_op_a;
        add_B     = r_op_b;
        result    = r_result;
        err       = r_err;
    end

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Directed bench for mpadder_arbiter with a 2-word-latency adder model that can be made to hang.
module tb_mpadder_arbiter;

    localparam int unsigned WIDTH   = 128;
    localparam int unsigned TIMEOUT = 15;

    logic             clk;
    logic             resetn;
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH:0]   result;
    logic             err;
    logic             add_start;
    logic [WIDTH-1:0] add_A;
    logic [WIDTH-1:0] add_B;
    logic [WIDTH:0]   add_C;
    logic             add_done;

    logic             hang;
    int               m_cnt;
    int               n_checks;
    int               n_errors;

    mpadder_arbiter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .result    (result),
        .err       (err),
        .add_start (add_start),
        .add_A     (add_A),
        .add_B     (add_B),
        .add_C     (add_C),
        .add_done  (add_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Adder model: done is high on the third cycle after the start cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cnt    <= 0;
            add_done <= 1'b0;
            add_C    <= '0;
        end else begin
            add_done <= 1'b0;
            if (add_start) begin
                m_cnt <= 2;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && !hang) begin
                    add_done <= 1'b1;
                    add_C    <= {1'b0, add_A} + {1'b0, add_B};
                end
            end
        end
    end

    task automatic wait_any(input int limit, output int cycles, output int which);
        cycles = 0;
        which  = 2;
        while (cycles < limit && which == 2) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done0) which = 0;
            else if (done1) which = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({gnt0, gnt1, done0, done1, err, add_start} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl got %b want 000000", {gnt0, gnt1, done0, done1, err, add_start});
        end
        n_checks++;
        if (result !== '0) begin
            n_errors++;
            $display("FAIL reset_result got %0h want 0", result);
        end
        n_checks++;
        if (add_A !== '0 || add_B !== '0) begin
            n_errors++;
            $display("FAIL reset_operands got %0h/%0h want 0/0", add_A, add_B);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single();
        int cyc;
        int who;
        logic [WIDTH:0] exp_sum;
        exp_sum = {1'b1, {WIDTH{1'b0}}};
        @(negedge clk);
        req0 = 1'b1;
        a0   = {1'b1, {(WIDTH - 1){1'b0}}};
        b0   = {1'b1, {(WIDTH - 1){1'b0}}};
        @(posedge clk);
        #1;
        n_checks++;
        if (add_start !== 1'b1 || gnt0 !== 1'b1) begin
            n_errors++;
            $display("FAIL single_issue got start=%b gnt0=%b want 1 1", add_start, gnt0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (add_start !== 1'b0) begin
            n_errors++;
            $display("FAIL single_start_pulse got %b want 0", add_start);
        end
        wait_any(40, cyc, who);
        n_checks++;
        if (who !== 0 || cyc !== 3) begin
            n_errors++;
            $display("FAIL single_latency got who=%0d cyc=%0d want 0 3", who, cyc);
        end
        n_checks++;
        if (result !== exp_sum || gnt1 !== 1'b0 || gnt0 !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL single_result got %0h gnt=%b%b err=%b want %0h gnt=01 err=0",
                     result, gnt1, gnt0, err, exp_sum);
        end
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (done0 !== 1'b0 || gnt0 !== 1'b0) begin
            n_errors++;
            $display("FAIL single_after got done0=%b gnt0=%b want 0 0", done0, gnt0);
        end
    endtask

    task automatic test_contention();
        int cyc;
        int who;
        do_reset();
        @(negedge clk);
        req0 = 1'b1; a0 = 3; b0 = 4;
        req1 = 1'b1; a1 = 5; b1 = 7;
        wait_any(40, cyc, who);
        n_checks++;
        if (who !== 0 || cyc !== 5 || result !== 129'd7) begin
            n_errors++;
            $display("FAIL contention_first got who=%0d cyc=%0d res=%0d want 0 5 7", who, cyc, result);
        end
        @(negedge clk);
        req0 = 1'b0;
        wait_any(40, cyc, who);
        n_checks++;
        if (who !== 1 || cyc !== 6 || result !== 129'd12 || gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            n_errors++;
            $display("FAIL contention_second got who=%0d cyc=%0d res=%0d gnt=%b%b want 1 6 12 10",
                     who, cyc, result, gnt1, gnt0);
        end
        @(negedge clk);
        req1 = 1'b0;
    endtask

    task automatic test_round_robin();
        int cyc;
        int who;
        logic [WIDTH:0] exp_res;
        @(negedge clk);
        req0 = 1'b1; a0 = 10;  b0 = 20;
        req1 = 1'b1; a1 = 100; b1 = 1;
        for (int i = 0; i < 6; i++) begin
            exp_res = (i % 2 == 0) ? 129'd30 : 129'd101;
            wait_any(40, cyc, who);
            n_checks++;
            if (who !== (i % 2) || result !== exp_res) begin
                n_errors++;
                $display("FAIL rr_job%0d got who=%0d res=%0d want %0d %0d",
                         i, who, result, i % 2, exp_res);
            end
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_operand_stability();
        int cyc;
        int who;
        @(negedge clk);
        req0 = 1'b1; a0 = 'h1234; b0 = 'h10;
        @(posedge clk);
        #1;
        @(negedge clk);
        a0 = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if (add_A !== 128'h1234) begin
            n_errors++;
            $display("FAIL stable_add_A got %0h want 1234", add_A);
        end
        wait_any(40, cyc, who);
        n_checks++;
        if (who !== 0 || result !== 129'h1244) begin
            n_errors++;
            $display("FAIL stable_result got who=%0d res=%0h want 0 1244", who, result);
        end
        @(negedge clk);
        req0 = 1'b0;
    endtask

    task automatic test_reset_midjob();
        int cyc;
        int who;
        int pulses;
        @(negedge clk);
        req1 = 1'b1; a1 = 1; b1 = 2;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (gnt1 !== 1'b0 || add_start !== 1'b0 || result !== '0 || add_A !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs got gnt1=%b start=%b res=%0h A=%0h want all 0",
                     gnt1, add_start, result, add_A);
        end
        req1 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done0 || done1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_errors++;
            $display("FAIL midreset_no_done got %0d pulses want 0", pulses);
        end
        @(negedge clk);
        req0 = 1'b1; a0 = 3; b0 = 4;
        req1 = 1'b1; a1 = 9; b1 = 9;
        wait_any(40, cyc, who);
        n_checks++;
        if (who !== 0 || result !== 129'd7) begin
            n_errors++;
            $display("FAIL midreset_rearb got who=%0d res=%0d want 0 7", who, result);
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        int cyc;
        int who;
        hang = 1'b1;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_pre_err got %b want 0", err);
        end
        req0 = 1'b1; a0 = 1; b0 = 1;
        wait_any(60, cyc, who);
        n_checks++;
        if (who !== 0 || cyc !== TIMEOUT + 3) begin
            n_errors++;
            $display("FAIL timeout_latency got who=%0d cyc=%0d want 0 %0d", who, cyc, TIMEOUT + 3);
        end
        n_checks++;
        if (result !== '0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_result got res=%0h err=%b want 0 1", result, err);
        end
        @(negedge clk);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1 || gnt0 !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_sticky got err=%b gnt0=%b want 1 0", err, gnt0);
        end
        hang = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        hang     = 1'b0;
        resetn   = 1'b1;
        req0     = 1'b0;
        req1     = 1'b0;
        a0       = '0;
        b0       = '0;
        a1       = '0;
        b1       = '0;
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_operand_stability();
        test_reset_midjob();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
